// File: rtl/m_logconv_seq.sv
// Sequential log-domain converter: splits an unsigned N into its characteristic K
// (index of the leading one) and mantissa M (N normalised, leading one removed).
module m_logconv_seq #(
  parameter int wl_N = 32,
  parameter int wl_k = 5,
  parameter int wl_m = wl_N - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [wl_N-1:0] N,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [wl_k-1:0] K,
  output logic [wl_m-1:0] M,
  output logic            ZERO,
  output logic            BUSY,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Input side is ready only in IDLE; output side is valid only in DONE, where
  // K/M/ZERO stay frozen until the consumer takes them.

  typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [wl_N-1:0] work;
  logic [wl_N-1:0] work_nx;
  logic [wl_N-1:0] shamt;
  logic [wl_k-1:0] cnt;
  logic [wl_k-1:0] msb_idx;

  // Priority encoder: the highest set bit wins; an all-zero word encodes as 0.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < wl_N; i++) begin
      if (work[i]) msb_idx = wl_k'(i);
    end
  end

  // Stage cnt normalises by 2**cnt whenever the matching K bit is clear, so the
  // total left shift over all stages is ~K = wl_N-1-K.
  always_comb begin
    shamt   = {{(wl_N-1){1'b0}}, 1'b1} << cnt;
    work_nx = K[cnt] ? work : (work << shamt);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (IN_VALID) state_nx = DETECT;
      DETECT:  state_nx = (work == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == '0) state_nx = DONE;
      DONE:    if (OUT_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state == IDLE) && !rst;
    OUT_VALID = (state == DONE);
    BUSY      = (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
      K    <= '0;
      M    <= '0;
      ZERO <= 1'b0;
    end else begin
      case (state)
        IDLE: if (IN_VALID) work <= N;
        DETECT: begin
          K    <= msb_idx;
          M    <= '0;
          ZERO <= (work == '0);
          cnt  <= wl_k'(wl_k - 1);
        end
        SHIFT: begin
          work <= work_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) M <= work_nx[wl_m-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
